// File: rtl/ebpc_decoder_ctrl.sv
// ebpc_decoder_ctrl: job-level sequencer for one symbol_decoder and its input unpacker
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/num_blocks_i/abort_i job control;
//   busy_o/done_o/err_o/blocks_done_o job status; dec_clr_o soft clear to decoder and unpacker;
//   in_vld_i/in_rdy_o unpacker side, in_vld_o/in_rdy_i decoder data side;
//   dec_push_i/dec_vld_i/dec_rdy_o decoder output side; space_ok_i downstream FIFO headroom.
// Optional stall watchdog: define EBPC_DEC_CTRL_WDT_EN.
module ebpc_decoder_ctrl #(
    parameter int CNT_W      = 24,
    parameter int WDT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_blocks_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blocks_done_o,
    output logic             dec_clr_o,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic             in_vld_o,
    input  logic             in_rdy_i,
    input  logic             dec_push_i,
    input  logic             dec_vld_i,
    output logic             dec_rdy_o,
    input  logic             space_ok_i
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, cnt_q, cnt_d;
    logic             blk_active_q, blk_active_d, ab_q, ab_d;
    logic             run, good_vld, trip;

    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("WDT_CYCLES must be at least 1");
    end

    assign run      = state_q == RUN;
    // a block end seen after the job's quota is a protocol error and is not counted
    assign good_vld = dec_vld_i & (cnt_q != num_q);

`ifdef EBPC_DEC_CTRL_WDT_EN
    localparam int               WDT_W   = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             err_q, err_d;
    logic             stall;
    assign stall = run & blk_active_q & ~dec_push_i;
    assign wdt_d = stall ? wdt_q + 1'b1 : '0;
    // trips on the WDT_CYCLES-th consecutive stalled cycle
    assign trip  = stall & (wdt_q == WDT_MAX);
    assign err_d = (state_q == IDLE && start_i) ? 1'b0 : (err_q | trip);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign trip  = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            num_q        <= '0;
            cnt_q        <= '0;
            blk_active_q <= 1'b0;
            ab_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            blk_active_q <= blk_active_d;
            ab_q         <= ab_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        cnt_d        = cnt_q;
        blk_active_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = CLEAR;
                num_d   = num_blocks_i;
                cnt_d   = '0;
            end
            CLEAR: state_d = (ab_q | abort_i) ? IDLE : (num_q == '0) ? DONE : RUN;
            RUN: begin
                blk_active_d = dec_vld_i ? 1'b0 : (dec_push_i | blk_active_q);
                if (abort_i | trip) state_d = CLEAR;
                else if (good_vld) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == num_q) ? DONE : RUN;
                end
            end
            DONE: state_d = abort_i ? CLEAR : IDLE;
        endcase
        // CLEAR entered from a busy state was caused by abort or watchdog and must end in IDLE
        ab_d = (state_d == CLEAR) && (state_q != IDLE);
    end

    always_comb begin
        busy_o        = state_q != IDLE;
        done_o        = state_q == DONE;
        dec_clr_o     = state_q == CLEAR;
        blocks_done_o = cnt_q;
        in_vld_o      = run & in_vld_i;
        in_rdy_o      = run & in_rdy_i;
        // an open block keeps rdy high regardless of headroom; the decoder needs it until block end
        dec_rdy_o     = run & (blk_active_q | (space_ok_i & (cnt_q != num_q)));
    end

    a_no_extra_blk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(run && dec_vld_i && cnt_q == num_q));
endmodule

// File: tb/tb_ebpc_decoder_ctrl.sv
// tb_ebpc_decoder_ctrl: scoreboard bench for ebpc_decoder_ctrl
module tb_ebpc_decoder_ctrl;
    localparam int CNT_W = 24;
    localparam int K_CLR = 0, K_CNT = 1, K_DONE = 2, K_IDLE = 3, K_ERR = 4;

    logic             clk_i = 1'b0, rst_ni = 1'b0;
    logic             start_i, abort_i, in_vld_i, in_rdy_i, dec_push_i, dec_vld_i, space_ok_i;
    logic [CNT_W-1:0] num_blocks_i;
    logic             busy_o, done_o, err_o, dec_clr_o, in_rdy_o, in_vld_o, dec_rdy_o;
    logic [CNT_W-1:0] blocks_done_o;

    typedef struct {int k; int v; int c;} ev_t;
    ev_t   q[$];
    string kn[5] = '{"clr", "cnt", "done", "idle", "err"};
    int    cyc = 0, n_tests = 0, n_fail = 0, mcnt = 0, merr = 0;
    int    prev_cnt = 0;
    logic  prev_busy = 1'b0, prev_err = 1'b0;

    ebpc_decoder_ctrl #(.CNT_W(CNT_W), .WDT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_blocks_i(num_blocks_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .blocks_done_o(blocks_done_o), .dec_clr_o(dec_clr_o), .in_vld_i(in_vld_i),
        .in_rdy_o(in_rdy_o), .in_vld_o(in_vld_o), .in_rdy_i(in_rdy_i), .dec_push_i(dec_push_i),
        .dec_vld_i(dec_vld_i), .dec_rdy_o(dec_rdy_o), .space_ok_i(space_ok_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic expect_ev(int k, int v, int c);
        q.push_back('{k, v, c});
    endtask

    task automatic got(int k, int v);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got value %0d at cycle %0d, required no event", kn[k], v, cyc);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.v != v || e.c != cyc) begin
                n_fail++;
                $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kn[e.k], kn[k], v, cyc, kn[e.k], e.v, e.c);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (dec_clr_o) got(K_CLR, 0);
            if (int'(blocks_done_o) != prev_cnt) got(K_CNT, int'(blocks_done_o));
            if (done_o) got(K_DONE, 0);
            if (!busy_o && prev_busy) got(K_IDLE, 0);
            if (err_o != prev_err) got(K_ERR, int'(err_o));
        end
        prev_cnt  = int'(blocks_done_o);
        prev_busy = busy_o;
        prev_err  = err_o;
    end

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(int n);
        start_i      = 1'b1;
        num_blocks_i = CNT_W'(n);
        expect_ev(K_CLR, 0, cyc + 1);
        if (mcnt != 0) expect_ev(K_CNT, 0, cyc + 1);
        if (merr != 0) expect_ev(K_ERR, 0, cyc + 1);
        if (n == 0) begin
            expect_ev(K_DONE, 0, cyc + 2);
            expect_ev(K_IDLE, 0, cyc + 3);
        end
        mcnt = 0;
        merr = 0;
        step();
        start_i = 1'b0;
        chk("gate_clear", int'({in_vld_o, in_rdy_o, dec_rdy_o}), 0);
        step();
    endtask

    task automatic block(bit last);
        dec_push_i = 1'b1;
        dec_vld_i  = 1'b0;
        step();
        dec_vld_i = 1'b1;
        mcnt++;
        expect_ev(K_CNT, mcnt, cyc + 1);
        if (last) begin
            expect_ev(K_DONE, 0, cyc + 1);
            expect_ev(K_IDLE, 0, cyc + 2);
        end
        step();
        dec_push_i = 1'b0;
        dec_vld_i  = 1'b0;
    endtask

    initial begin
        start_i = 1'b0; abort_i = 1'b0; num_blocks_i = '0;
        in_vld_i = 1'b1; in_rdy_i = 1'b1; dec_push_i = 1'b0; dec_vld_i = 1'b0; space_ok_i = 1'b1;
        repeat (2) step();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_clr", int'(dec_clr_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_blocks", int'(blocks_done_o), 0);
        chk("rst_gate", int'({in_vld_o, in_rdy_o, dec_rdy_o}), 0);
        rst_ni = 1'b1;
        step();

        start_job(3);
        chk("run_in_vld", int'(in_vld_o), 1);
        chk("run_in_rdy", int'(in_rdy_o), 1);
        chk("run_dec_rdy", int'(dec_rdy_o), 1);
        block(1'b0);
        block(1'b0);
        block(1'b1);
        step();

        start_job(0);
        chk("zero_gate_done", int'({in_vld_o, in_rdy_o, dec_rdy_o}), 0);
        step();
        chk("zero_gate_idle", int'({in_vld_o, in_rdy_o, dec_rdy_o}), 0);
        step();

        start_job(2);
        dec_push_i = 1'b1;
        step();
        dec_push_i = 1'b0;
        space_ok_i = 1'b0;
        #1;
        chk("rdy_hold", int'(dec_rdy_o), 1);
        step();
        chk("rdy_hold2", int'(dec_rdy_o), 1);
        dec_push_i = 1'b1;
        dec_vld_i  = 1'b1;
        mcnt++;
        expect_ev(K_CNT, mcnt, cyc + 1);
        step();
        dec_push_i = 1'b0;
        dec_vld_i  = 1'b0;
        chk("rdy_drop", int'(dec_rdy_o), 0);
        step();
        chk("rdy_drop2", int'(dec_rdy_o), 0);
        space_ok_i = 1'b1;
        #1;
        chk("rdy_rise", int'(dec_rdy_o), 1);
        block(1'b1);
        step();

        start_job(1);
        dec_push_i = 1'b1;
        step();
        dec_vld_i = 1'b1;
        abort_i   = 1'b1;
        expect_ev(K_CLR, 0, cyc + 1);
        expect_ev(K_IDLE, 0, cyc + 2);
        step();
        dec_push_i = 1'b0;
        dec_vld_i  = 1'b0;
        abort_i    = 1'b0;
        step();
        chk("abort_idle_busy", int'(busy_o), 0);
        step();

        start_job(2);
        start_i      = 1'b1;
        num_blocks_i = CNT_W'(7);
        step();
        start_i = 1'b0;
        chk("busy_start_blocks", int'(blocks_done_o), 0);
        chk("busy_start_busy", int'(busy_o), 1);
        block(1'b0);
        block(1'b1);
        step();

        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        step();
        chk("abort_in_idle", int'(busy_o), 0);

`ifdef EBPC_DEC_CTRL_WDT_EN
        start_job(1);
        dec_push_i = 1'b1;
        step();
        dec_push_i = 1'b0;
        expect_ev(K_CLR, 0, cyc + 16);
        expect_ev(K_ERR, 1, cyc + 16);
        expect_ev(K_IDLE, 0, cyc + 17);
        repeat (18) step();
        chk("wdt_err_sticky", int'(err_o), 1);
        merr = 1;
        start_job(1);
        abort_i = 1'b1;
        expect_ev(K_CLR, 0, cyc + 1);
        expect_ev(K_IDLE, 0, cyc + 2);
        step();
        abort_i = 1'b0;
        step();
`endif

        repeat (4) step();
        while (q.size() != 0) begin
            ev_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_%s: got no event, required value %0d at cycle %0d", kn[e.k], e.v, e.c);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ebpc_decoder_ctrl.md
# ebpc_decoder_ctrl

Job-level controller that sequences one `symbol_decoder` and its input unpacker for one decode job of N BPC blocks. It sits between the stream unpacker, the `symbol_decoder` and the downstream output FIFO. It soft-clears the decoder at job boundaries and gates the input and output handshakes. It counts completed blocks, raises `done_o` when the job finishes, and supports abort and an optional stall watchdog.

## Interface
Parameters:
- `CNT_W`, 24: width of the block counter and `num_blocks_i`.
- `WDT_CYCLES`, 1024: watchdog limit in cycles; used only with `EBPC_DEC_CTRL_WDT_EN`.

Ports:
- `clk_i` in 1: clock; the single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start a job; sampled only in IDLE.
- `num_blocks_i` in CNT_W: number of blocks in the job; latched on an accepted start.
- `abort_i` in 1: terminate the current job.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when a job completes normally.
- `err_o` out 1: sticky watchdog error; cleared by the next accepted start.
- `blocks_done_o` out CNT_W: count of blocks completed in the current job.
- `dec_clr_o` out 1: soft clear to the decoder and the unpacker.
- `in_vld_i` in 1, `in_rdy_o` out 1: handshake with the unpacker.
- `in_vld_o` out 1, `in_rdy_i` in 1: handshake with the decoder (`data_vld_i` / `data_rdy_o`).
- `dec_push_i` in 1: decoder `push_o`.
- `dec_vld_i` in 1: decoder `vld_o`, which marks the last word of a block.
- `dec_rdy_o` out 1: drives the decoder `rdy_i`.
- `space_ok_i` in 1: downstream FIFO holds at least DATA_W+1 free words.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - On `start_i`, latch `num_blocks_i` into `num_q`, zero `blocks_done_o`, clear `err_o`, then go to CLEAR.
- CLEAR:
  - Assert `dec_clr_o` for exactly one cycle.
  - Next state: IDLE if the cycle was entered through an abort or a watchdog trip; DONE if `num_q == 0`; otherwise RUN.
- RUN:
  - `in_vld_o = in_vld_i`, `in_rdy_o = in_rdy_i`.
  - `dec_rdy_o = blk_active_q | (space_ok_i & (blocks_done_o != num_q))`.
  - `blk_active_q` is set on `dec_push_i & ~dec_vld_i` and cleared on `dec_vld_i`.
  - Once a block is active, `dec_rdy_o` stays high until that block's `dec_vld_i`. The decoder requires `rdy_i` high throughout a block.
  - On `dec_vld_i`, `blocks_done_o` increments. If the new value equals `num_q`, go to DONE.
- DONE:
  - `done_o = 1` for one cycle, then go to IDLE. No clear is issued here; the next start performs one.
- Outside RUN: `in_vld_o = 0`, `in_rdy_o = 0`, `dec_rdy_o = 0`.
- Abort:
  - `abort_i` in RUN or DONE forces CLEAR, then IDLE. No `done_o` pulse.
  - Abort in CLEAR still proceeds to IDLE.
  - Abort in IDLE is ignored.
  - Abort has priority over a simultaneous `dec_vld_i` or completion.
- `start_i` outside IDLE is ignored.
- `blocks_done_o` wraps modulo 2^CNT_W and never exceeds `num_q` in normal use.
- `dec_vld_i` while `blocks_done_o == num_q` is a protocol error: flag it with a simulation assertion and do not count it.

## Timing
- Reset values: state IDLE, all outputs 0, `blocks_done_o = 0`, `blk_active_q = 0`.
- An accepted `start_i` at cycle t gives:
  - `busy_o` and `dec_clr_o` high at t+1;
  - RUN gating open at t+2.
- The last `dec_vld_i` at cycle t gives `done_o` high at t+1 and `busy_o` low at t+2.
- With `num_blocks_i = 0`: start at t, `dec_clr_o` at t+1, `done_o` at t+2.
- `abort_i` at t gives `dec_clr_o` at t+1 and IDLE at t+2.
- All outputs are registered state decodes or single-level gating. There is no combinational path from `start_i` or `abort_i` to any output.

## Configuration
- `EBPC_DEC_CTRL_WDT_EN` defined:
  - A counter runs in RUN while `blk_active_q` is high and resets on every `dec_push_i`.
  - When it reaches `WDT_CYCLES`, set `err_o` (sticky) and go to CLEAR, then IDLE. No `done_o` pulse.
- `EBPC_DEC_CTRL_WDT_EN` undefined:
  - No counter is instantiated and `err_o` is tied to 0.

## Test plan
- Reset, then start with `num_blocks_i = 3`, `space_ok_i = 1`, and the decoder model emitting 3 blocks:
  - one `dec_clr_o` pulse at t+1;
  - `blocks_done_o` steps 1, 2, 3;
  - `done_o` pulses one cycle after the third `dec_vld_i`.
- Start with `num_blocks_i = 0`:
  - `dec_clr_o` at t+1, `done_o` at t+2;
  - `in_rdy_o`, `in_vld_o` and `dec_rdy_o` never go high.
- Drop `space_ok_i` mid-block:
  - `dec_rdy_o` stays high until that block's `dec_vld_i`, then goes low;
  - it rises again when `space_ok_i` returns.
- `abort_i` in the same cycle as the final `dec_vld_i`:
  - `dec_clr_o` next cycle, IDLE after that;
  - `done_o` never pulses.
- With `EBPC_DEC_CTRL_WDT_EN` and `WDT_CYCLES = 16`, stall pushes mid-block:
  - `err_o` rises after 16 idle cycles, then CLEAR, then IDLE;
  - the next start clears `err_o`.
- `start_i` pulsed while busy:
  - ignored; `num_q` and `blocks_done_o` unchanged.
